disp_arb: RTL

DISP_ARB -- requirements
Module: disp_arb

---
 rtl/disp_arb.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/disp_arb.sv
// disp_arb: fixed-priority three-channel arbiter for a scan4 display with a minimum hold time per grant.
// Optional feature macro DISP_ARB_BLINK_EN: the error payload blinks on the display tick while it owns the digits.
module disp_arb #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned HOLD_TICKS = 4,
    parameter logic [3:0]  BLANK      = 4'hb
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  req,
    input  logic [15:0] p2,
    input  logic [15:0] p1,
    input  logic [15:0] p0,
    output logic [2:0]  gnt,
    output logic [3:0]  d3,
    output logic [3:0]  d2,
    output logic [3:0]  d1,
    output logic [3:0]  d0,
    output logic        busy
);

    localparam int unsigned      CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]       HOLD_MAX  = 4'(HOLD_TICKS);
    localparam logic [15:0]      ALL_BLANK = {4{BLANK}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [3:0]       hold_q, hold_d;
    logic [15:0]      dig_q, dig_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             tick;
    logic             owner_req;
    logic             grant_chg;
    logic [15:0]      dig_show;

    function automatic logic [2:0] top_req(input logic [2:0] r);
        logic [2:0] g;
        g = 3'b000;
        if (r[2])      g = 3'b100;
        else if (r[1]) g = 3'b010;
        else if (r[0]) g = 3'b001;
        return g;
    endfunction

    // Requests strictly above the current owner in priority.
    function automatic logic [2:0] above(input logic [2:0] g);
        return {g[1] | g[0], g[0], 1'b0};
    endfunction

    function automatic logic [15:0] pick(input logic [2:0]  g,
                                         input logic [15:0] a2,
                                         input logic [15:0] a1,
                                         input logic [15:0] a0);
        logic [15:0] v;
        v = a0;
        if (g[2])      v = a2;
        else if (g[1]) v = a1;
        return v;
    endfunction

    assign tick      = en && (tcnt_q == TICK_LAST);
    assign tcnt_d    = tick ? '0 : tcnt_q + CNT_W'(1);
    assign owner_req = |(req & gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;
        dig_d   = dig_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = HOLD;
                    gnt_d   = top_req(req);
                    hold_d  = 4'd0;
                end
            end
            HOLD: begin
                if (tick && (hold_q < HOLD_MAX)) begin
                    hold_d = hold_q + 4'd1;
                    if (hold_q + 4'd1 == HOLD_MAX) state_d = OPEN;
                end
            end
            OPEN: begin
                // Preemption wins even when the owner is still requesting.
                if (|(req & above(gnt_q))) begin
                    state_d = HOLD;
                    gnt_d   = top_req(req);
                    hold_d  = 4'd0;
                end else if (!owner_req) begin
                    gnt_d  = top_req(req);
                    hold_d = 4'd0;
                    state_d = (|req) ? HOLD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                hold_d  = 4'd0;
            end
        endcase

        grant_chg = (gnt_d != gnt_q);

        // A new owner shows its payload at once; an owner that dropped its request freezes the digits.
        if (gnt_d == 3'b000)  dig_d = ALL_BLANK;
        else if (grant_chg)   dig_d = pick(gnt_d, p2, p1, p0);
        else if (owner_req)   dig_d = pick(gnt_q, p2, p1, p0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            hold_q  <= 4'd0;
            dig_q   <= ALL_BLANK;
            tcnt_q  <= '0;
        end else if (!en) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            hold_q  <= 4'd0;
            dig_q   <= ALL_BLANK;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            dig_q   <= dig_d;
            tcnt_q  <= tcnt_d;
        end
    end

`ifdef DISP_ARB_BLINK_EN
    logic phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (grant_chg)             phase_d = 1'b0;
        else if (gnt_q[2] && tick) phase_d = ~phase_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      phase_q <= 1'b0;
        else if (!en)  phase_q <= 1'b0;
        else           phase_q <= phase_d;
    end

    assign dig_show = (gnt_q[2] && phase_q) ? ALL_BLANK : dig_q;
`else
    assign dig_show = dig_q;
`endif

    assign gnt  = gnt_q;
    assign busy = (state_q != IDLE);
    assign d3   = dig_show[15:12];
    assign d2   = dig_show[11:8];
    assign d1   = dig_show[7:4];
    assign d0   = dig_show[3:0];

endmodule
